bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 Parameter: DW, 128, BRAM word width in bits.
REQ-002 Parameter: WL, 256, BRAM depth in words.
REQ-003 Parameter: AW, 13, BRAM byte-address width; word index placed at bram_A[9:2], other bits 0.
REQ-004 Port: CLK  input  1  single clock, all logic on rising edge.
REQ-005 Port: RSTN  input  1  asynchronous active-low reset.
REQ-006 Port: start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 Port: base  input  8  first word index, sampled with start.
REQ-008 Port: len  input  9  word count, sampled with start.
REQ-009 Port: busy  output  1  high from the accepted start until the last beat handshakes.
REQ-010 Port: done  output  1  one-cycle pulse after the last beat (or after a zero-length request).
REQ-011 Port: bram_EN  output  1  BRAM read enable.
REQ-012 Port: bram_WE  output  4  constant 4'b0000.
REQ-013 Port: bram_A  output  AW  BRAM byte address.
REQ-014 Port: bram_Do  input  DW  BRAM read data, valid the cycle after the enabled edge.
REQ-015 Port: m_tvalid / m_tready / m_tdata[DW] / m_tlast  out/in/out/out  AXI-Stream master.

Function
REQ-016 FSM states: IDLE, RUN, DRAIN. IDLE->RUN on start with len!=0. RUN->DRAIN after the last read issues. DRAIN->IDLE when the beat carrying m_tlast handshakes.
REQ-017 start with len==0: stay in IDLE, pulse done on the next cycle, issue no read.
REQ-018 len>256: saturate to 256.
REQ-019 Read address: word index (base+i) mod WL, i=0..len-1; wrap 255->0 is legal.
REQ-020 A read is issued only when (skid occupancy + reads in flight) < 2, so no beat is ever dropped under back-pressure.
REQ-021 bram_Do is captured into a 2-entry skid buffer the cycle after its read edge.
REQ-022 m_tdata and m_tvalid are driven from the skid head (registered, no combinational path from bram_Do).
REQ-023 Latency: start sampled at edge T -> bram_EN high in cycle T+1 -> first m_tvalid in cycle T+3.
REQ-024 Throughput: with m_tready held high, 1 beat per cycle sustained.
REQ-025 m_tlast is high on exactly the final beat.
REQ-026 m_tvalid, once high, holds with m_tdata stable until m_tready.
REQ-027 start while busy is ignored; base and len changes while busy are ignored.
REQ-028 done and m_tlast handshake: done pulses in the cycle after the tlast handshake.
REQ-029 busy is low in the done cycle.

Reset
REQ-030 Asserting RSTN low, including mid-transfer, asynchronously forces: IDLE, skid empty, in-flight count 0, and all outputs 0 (bram_A=0, busy=0, done=0, m_tvalid=0, m_tlast=0, m_tdata=0).
REQ-031 The aborted transfer does not resume after reset release and produces no done pulse.

Configuration
REQ-032 BRAM_RD_STALL_CNT_EN defined adds output stall_cnt[31:0], which counts cycles with m_tvalid && !m_tready, saturates at all-ones, and clears on reset and on each accepted start.
REQ-033 BRAM_RD_STALL_CNT_EN undefined: no port and no counter logic.

Structure
REQ-034 Shared package bram_rd_pkg holds the DW/WL/AW defaults and the FSM state enum.
REQ-035 One sub-module, bram_rd_skid, implements the 2-entry valid/ready buffer with registered outputs.

Verification
REQ-036 base=0, len=4, m_tready=1 -> bram_A=0,4,8,12 on consecutive cycles; 4 beats on consecutive cycles from T+3; tlast on beat 4; done one cycle later.
REQ-037 base=254, len=4 -> word indices 254,255,0,1 (bram_A=1016,1020,0,4), in order.
REQ-038 len=8, m_tready toggled 1,0,0,1 repeating -> all 8 words delivered in order, none lost or duplicated, m_tdata stable while stalled, occupancy never exceeds 2.
REQ-039 len=0 -> no bram_EN, no m_tvalid, done pulse at T+1; len=300 -> exactly 256 beats.
REQ-040 RSTN low at beat 3 of len=16 -> all outputs 0 immediately; after release IDLE, no done; new start len=2 completes normally.
REQ-041 With BRAM_RD_STALL_CNT_EN defined: len=4 with m_tready low for 5 cycles after first tvalid -> stall_cnt=5.

Source files
------------

// File: rtl/bram_rd_pkg.sv
// Shared definitions for the BRAM stream reader: default geometry and FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package bram_rd_pkg;

  localparam int DW_DEF  = 128;  // BRAM word width in bits
  localparam int WL_DEF  = 256;  // BRAM depth in words
  localparam int AW_DEF  = 13;   // BRAM byte-address width
  localparam int LEN_MAX = 256;  // requested lengths above this are clipped

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/bram_rd_skid.sv
// Two-entry valid/ready buffer with registered outputs, holding BRAM read data.
// Latency: a push is visible on pop_vld/pop_dat in the cycle after the push edge.
// Backpressure: holds up to two words; the producer must never push into a full
//   buffer unless a pop happens in the same cycle (caller tracks this via occ).
// Ports: CLK/RSTN; push_vld/push_dat/push_last (write side);
//   pop_vld/pop_rdy/pop_dat/pop_last (read side); occ = current entry count.
module bram_rd_skid
  import bram_rd_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          push_vld,
  input  logic [DW-1:0] push_dat,
  input  logic          push_last,
  output logic          pop_vld,
  input  logic          pop_rdy,
  output logic [DW-1:0] pop_dat,
  output logic          pop_last,
  output logic [1:0]    occ
);

  logic [DW-1:0] head_dat_q;
  logic [DW-1:0] tail_dat_q;
  logic          head_last_q;
  logic          tail_last_q;
  logic [1:0]    occ_q;
  logic          pop;

  assign pop = (occ_q != 2'd0) && pop_rdy;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      head_dat_q  <= '0;
      tail_dat_q  <= '0;
      head_last_q <= 1'b0;
      tail_last_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      case ({push_vld, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            head_dat_q  <= push_dat;
            head_last_q <= push_last;
            occ_q       <= 2'd1;
          end else if (occ_q == 2'd1) begin
            tail_dat_q  <= push_dat;
            tail_last_q <= push_last;
            occ_q       <= 2'd2;
          end
          // occ_q == 2 with no pop cannot occur: reads are only issued when a slot is free
        end
        2'b01: begin
          if (occ_q == 2'd2) begin
            head_dat_q  <= tail_dat_q;
            head_last_q <= tail_last_q;
            occ_q       <= 2'd1;
          end else begin
            // going empty: drop last so it never shows without valid
            head_last_q <= 1'b0;
            occ_q       <= 2'd0;
          end
        end
        2'b11: begin
          if (occ_q == 2'd2) begin
            head_dat_q  <= tail_dat_q;
            head_last_q <= tail_last_q;
            tail_dat_q  <= push_dat;
            tail_last_q <= push_last;
          end else begin
            head_dat_q  <= push_dat;
            head_last_q <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop_vld  = (occ_q != 2'd0);
  assign pop_dat  = head_dat_q;
  assign pop_last = head_last_q;
  assign occ      = occ_q;

endmodule

// File: rtl/bram_stream_reader.sv
// Streams len consecutive BRAM words (wrapping at WL) starting at base onto AXI-Stream.
// Latency: start sampled at edge T -> bram_EN in cycle T+1 -> first m_tvalid in cycle T+3.
// Backpressure: reads are throttled so skid entries plus in-flight reads never exceed 2.
// Ports: CLK, RSTN (async active-low); start/base/len request; busy/done status;
//   bram_EN/bram_WE/bram_A/bram_Do BRAM read port; m_t* AXI-Stream master.
// Optional: define BRAM_RD_STALL_CNT_EN to add stall_cnt[31:0], counting cycles with
//   m_tvalid && !m_tready (saturating, cleared on reset and on each accepted start).
module bram_stream_reader
  import bram_rd_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int WL = WL_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          start,
  input  logic [7:0]    base,
  input  logic [8:0]    len,
  output logic          busy,
  output logic          done,
  output logic          bram_EN,
  output logic [3:0]    bram_WE,
  output logic [AW-1:0] bram_A,
  input  logic [DW-1:0] bram_Do,
  output logic          m_tvalid,
  input  logic          m_tready,
  output logic [DW-1:0] m_tdata,
  output logic          m_tlast
`ifdef BRAM_RD_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cnt
`endif
);

  localparam int IW = $clog2(WL);

  rd_state_e     state_q, state_d;
  logic [IW-1:0] rd_idx_q;
  logic [8:0]    rem_q;
  logic          inflight_q;
  logic          inflight_last_q;
  logic          done_q;
  logic [1:0]    occ;
  logic          pop;
  logic          issue;
  logic          load;
  logic          done_d;
  logic [2:0]    slots;
  logic [8:0]    len_sat;

  assign len_sat = (len > 9'(LEN_MAX)) ? 9'(LEN_MAX) : len;

  // Slots count the beat leaving this cycle as already free; otherwise a
  // streaming transfer would stall every other cycle with only two entries.
  assign pop   = m_tvalid && m_tready;
  assign slots = {1'b0, occ} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = (state_q == RUN) && (slots < 3'd2);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len == 9'd0) begin
            done_d = 1'b1;
          end else begin
            load    = 1'b1;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (issue && (rem_q == 9'd1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (pop && m_tlast) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rd_idx_q        <= '0;
      rem_q           <= 9'd0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      done_q          <= done_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && (rem_q == 9'd1);
      if (load) begin
        rd_idx_q <= IW'(base);
        rem_q    <= len_sat;
      end else if (issue) begin
        rd_idx_q <= (rd_idx_q == IW'(WL - 1)) ? '0 : rd_idx_q + IW'(1);
        rem_q    <= rem_q - 9'd1;
      end
    end
  end

  // Address is only driven while a read is issued, so it idles at zero.
  always_comb begin
    bram_A = '0;
    if (issue) bram_A[IW+1:2] = rd_idx_q;
  end

  assign bram_EN = issue;
  assign bram_WE = 4'b0000;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

  bram_rd_skid #(
    .DW(DW)
  ) u_skid (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .push_vld (inflight_q),
    .push_dat (bram_Do),
    .push_last(inflight_last_q),
    .pop_vld  (m_tvalid),
    .pop_rdy  (m_tready),
    .pop_dat  (m_tdata),
    .pop_last (m_tlast),
    .occ      (occ)
  );

`ifdef BRAM_RD_STALL_CNT_EN
  logic start_acc;
  assign start_acc = start && (state_q == IDLE);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)                                               stall_cnt <= 32'd0;
    else if (start_acc)                                      stall_cnt <= 32'd0;
    else if (m_tvalid && !m_tready && (stall_cnt != '1))     stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_bram_stream_reader.sv
`timescale 1ns/1ps
module tb_bram_stream_reader;

  localparam int DW = 128;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          start;
  logic [7:0]    base;
  logic [8:0]    len;
  logic          busy;
  logic          done;
  logic          bram_EN;
  logic [3:0]    bram_WE;
  logic [12:0]   bram_A;
  logic [DW-1:0] bram_Do;
  logic          m_tvalid;
  logic          m_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tlast;
`ifdef BRAM_RD_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  always #5 CLK = ~CLK;

  bram_stream_reader dut (
    .CLK      (CLK),
    .RSTN     (RSTN),
    .start    (start),
    .base     (base),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .bram_EN  (bram_EN),
    .bram_WE  (bram_WE),
    .bram_A   (bram_A),
    .bram_Do  (bram_Do),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tlast  (m_tlast)
`ifdef BRAM_RD_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // BRAM contents and a one-cycle read-latency memory model
  logic [DW-1:0] mem [256];
  always @(posedge CLK) if (bram_EN) bram_Do <= mem[bram_A[9:2]];

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Observation of the DUT, sampled on the falling edge
  bit            mon_en = 1'b0;
  logic [12:0]   addr_q [$];
  logic [DW-1:0] bdat_q [$];
  bit            blast_q [$];
  int            bcyc_q [$];
  int            done_cyc_q [$];
  int            first_en, first_vld, nstall;
  bit            prev_stall;
  logic [DW-1:0] prev_dat;

  task automatic clear_mon();
    addr_q.delete(); bdat_q.delete(); blast_q.delete(); bcyc_q.delete(); done_cyc_q.delete();
    first_en = -1; first_vld = -1; nstall = 0; prev_stall = 1'b0;
  endtask

  always @(negedge CLK) begin
    if (mon_en) begin
      if (bram_EN) begin
        addr_q.push_back(bram_A);
        if (first_en < 0) first_en = cyc;
      end
      if (m_tvalid && first_vld < 0) first_vld = cyc;
      if (prev_stall) begin
        chk("hold_vld", DW'(m_tvalid), DW'(1'b1));
        chk("hold_dat", m_tdata, prev_dat);
      end
      if (m_tvalid && m_tready) begin
        bdat_q.push_back(m_tdata);
        blast_q.push_back(m_tlast);
        bcyc_q.push_back(cyc);
      end
      if (m_tvalid && !m_tready) nstall++;
      prev_stall = m_tvalid && !m_tready;
      prev_dat   = m_tdata;
      if (done) begin
        done_cyc_q.push_back(cyc);
        chk("busy_at_done", DW'(busy), DW'(1'b0));
      end
    end
  end

  // mode: 0 ready high, 1 ready pattern 1,0,0,1, 2 random ready, 3 stall 5 cycles then high
  task automatic run_xfer(input logic [7:0] b, input logic [8:0] l, input int mode, input bit inject);
    int nb, t0, budget, k, idx;
    bit fin;
    nb = (l > 9'd256) ? 256 : int'(l);
    clear_mon();
    mon_en = 1'b1;
    @(posedge CLK); #1;
    start = 1'b1; base = b; len = l;
    m_tready = (mode == 0) || (mode == 1);
    @(posedge CLK); #1;
    start = 1'b0; base = 8'($urandom); len = 9'($urandom);
    t0 = cyc;
    if (nb > 0) chk("busy_run", DW'(busy), DW'(1'b1));
    budget = 6 * nb + 40;
    fin = 1'b0;
    k = 1;
    while (!fin && k < budget) begin
      case (mode)
        0:       m_tready = 1'b1;
        1:       m_tready = (k % 4 == 0) || (k % 4 == 3);
        2:       m_tready = ($urandom_range(0, 3) != 0);
        default: m_tready = (nstall >= 5);
      endcase
      if (inject && k == 3) begin
        start = 1'b1; base = 8'($urandom); len = 9'($urandom_range(1, 511));
      end else begin
        start = 1'b0;
      end
      @(posedge CLK); #1;
      k++;
      if (done_cyc_q.size() > 0) fin = 1'b1;
    end
    start = 1'b0;
    chk("timeout", DW'(fin), DW'(1'b1));
    repeat (3) @(posedge CLK);
    #1;
    mon_en = 1'b0;

    chk("nbeats", DW'(bdat_q.size()), DW'(nb));
    chk("naddr", DW'(addr_q.size()), DW'(nb));
    for (int i = 0; i < nb; i++) begin
      idx = (int'(b) + i) % 256;
      if (i < addr_q.size()) chk("addr", DW'(addr_q[i]), DW'(idx * 4));
      if (i < bdat_q.size()) begin
        chk("dat", bdat_q[i], mem[idx]);
        chk("last", DW'(blast_q[i]), DW'(i == nb - 1));
      end
    end
    chk("ndone", DW'(done_cyc_q.size()), DW'(1));
    if (done_cyc_q.size() > 0) begin
      if (nb == 0) chk("done_lat0", DW'(done_cyc_q[0]), DW'(t0));
      else if (bcyc_q.size() > 0) chk("done_lat", DW'(done_cyc_q[0]), DW'(bcyc_q[bcyc_q.size() - 1] + 1));
    end
    if (nb == 0) begin
      chk("no_en", DW'(first_en < 0), DW'(1'b1));
      chk("no_vld", DW'(first_vld < 0), DW'(1'b1));
    end else if (mode == 0) begin
      chk("en_lat", DW'(first_en), DW'(t0));
      chk("vld_lat", DW'(first_vld), DW'(t0 + 2));
      if (bcyc_q.size() > 0) chk("thru", DW'(bcyc_q[bcyc_q.size() - 1] - bcyc_q[0]), DW'(nb - 1));
    end
    chk("busy_end", DW'(busy), DW'(1'b0));
    chk("we", DW'(bram_WE), DW'(4'b0000));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, DW'(busy), DW'(1'b0));
    chk({tag, "_done"}, DW'(done), DW'(1'b0));
    chk({tag, "_en"}, DW'(bram_EN), DW'(1'b0));
    chk({tag, "_addr"}, DW'(bram_A), DW'(13'd0));
    chk({tag, "_vld"}, DW'(m_tvalid), DW'(1'b0));
    chk({tag, "_last"}, DW'(m_tlast), DW'(1'b0));
    chk({tag, "_dat"}, m_tdata, DW'(0));
  endtask

  initial begin
    int k, quiet_bad, l;
    bit inj;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    RSTN = 1'b0; start = 1'b0; base = 8'd0; len = 9'd0; m_tready = 1'b0;
    clear_mon();
    repeat (3) @(posedge CLK);
    #1;
    chk_outputs_zero("reset");
    @(negedge CLK) RSTN = 1'b1;

    run_xfer(8'd0, 9'd4, 0, 1'b0);
    run_xfer(8'd254, 9'd4, 0, 1'b0);
    run_xfer(8'($urandom), 9'd8, 1, 1'b0);
    run_xfer(8'($urandom), 9'd0, 0, 1'b0);
    run_xfer(8'($urandom), 9'd300, 0, 1'b0);

    // Reset in the middle of a transfer, as the third beat is presented
    clear_mon();
    mon_en = 1'b1;
    @(posedge CLK); #1;
    start = 1'b1; base = 8'($urandom); len = 9'd16; m_tready = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    k = 0;
    while (bdat_q.size() < 2 && k < 100) begin
      @(posedge CLK); #1;
      k++;
    end
    chk("rst_reach", DW'(bdat_q.size() >= 2), DW'(1'b1));
    mon_en = 1'b0;
    RSTN = 1'b0;
    #1;
    chk_outputs_zero("midrst");
    repeat (2) @(posedge CLK);
    @(negedge CLK) RSTN = 1'b1;
    quiet_bad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (done || m_tvalid || bram_EN || busy) quiet_bad++;
    end
    chk("rst_quiet", DW'(quiet_bad), DW'(0));
    run_xfer(8'($urandom), 9'd2, 0, 1'b0);

    // Randomized transfers, some with a start pulse injected while busy
    for (int t = 0; t < 8; t++) begin
      l = $urandom_range(1, 40);
      inj = (l >= 4) && ($urandom_range(0, 1) == 1);
      run_xfer(8'($urandom), 9'(l), $urandom_range(0, 2), inj);
    end

`ifdef BRAM_RD_STALL_CNT_EN
    run_xfer(8'($urandom), 9'd4, 3, 1'b0);
    chk("stall_cnt", DW'(stall_cnt), DW'(32'd5));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
